// File: rtl/simple_rx_checker_if.sv
// AXI4-Stream beat bundle between the TX packet generator (master) and the
// rx checker (slave).
interface simple_rx_checker_if #(
  parameter int C_DATA_WIDTH  = 64,
  parameter int C_TUSER_WIDTH = 128
) ();
  logic [C_DATA_WIDTH-1:0]    S_AXIS_TDATA;
  logic [C_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB;
  logic [C_TUSER_WIDTH-1:0]   S_AXIS_TUSER;
  logic                       S_AXIS_TVALID;
  logic                       S_AXIS_TREADY;
  logic                       S_AXIS_TLAST;

  modport master (
    output S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TUSER, S_AXIS_TVALID, S_AXIS_TLAST,
    input  S_AXIS_TREADY
  );

  modport slave (
    input  S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TUSER, S_AXIS_TVALID, S_AXIS_TLAST,
    output S_AXIS_TREADY
  );
endinterface

// File: rtl/simple_rx_checker.sv
// Stream sink that checks header/body beats from the simple TX generator,
// counts good/bad packets and accepted beats, and throttles TREADY by a mask.
module simple_rx_checker #(
  parameter int                  C_S_AXIS_DATA_WIDTH  = 64,
  parameter int                  C_S_AXIS_TUSER_WIDTH = 128,
  parameter logic [63:0]         C_EXP_HDR            = 64'hAAAA_AAAA_AAAA_AAAA,
  parameter logic [63:0]         C_EXP_BODY           = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter logic [15:0]         C_EXP_LEN            = 16'h0040,
  parameter int                  C_EXP_BEATS          = 2
) (
  input  logic                   S_AXI_ACLK,
  input  logic                   S_AXI_ARESETN,
  simple_rx_checker_if.slave     s_axis,
  input  logic                   rst_cntrs,
  input  logic [3:0]             ready_mask,
  output logic [31:0]            good_pkt_cnt,
  output logic [31:0]            bad_pkt_cnt,
  output logic [31:0]            beat_cnt,
  output logic [3:0]             err_flags,
  output logic                   in_packet
);

  localparam int IDX_W = $clog2(C_EXP_BEATS + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(C_EXP_BEATS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BODY = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         phase_q;
  logic [31:0]        good_pkt_cnt_q, bad_pkt_cnt_q, beat_cnt_q;
  logic [3:0]         err_flags_q;
  logic               in_packet_q;

  logic               accept_s;
  logic               good_inc_s, bad_inc_s;
  logic [3:0]         err_set_s;
  logic               strb_ok_s;
  logic               hdr_data_err_s, hdr_user_err_s, body_err_s;
  logic [IDX_W-1:0]   idx_inc_s;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    if (en && (v != 32'hFFFF_FFFF)) begin
      return v + 32'd1;
    end else begin
      return v;
    end
  endfunction

  assign s_axis.S_AXIS_TREADY = ready_mask[phase_q];
  assign accept_s = s_axis.S_AXIS_TVALID & s_axis.S_AXIS_TREADY;

  assign strb_ok_s      = &s_axis.S_AXIS_TSTRB;
  // A header with partial strobes is reported as a header data error.
  assign hdr_data_err_s = (s_axis.S_AXIS_TDATA != C_S_AXIS_DATA_WIDTH'(C_EXP_HDR)) | ~strb_ok_s;
  assign hdr_user_err_s = (s_axis.S_AXIS_TUSER[15:0] != C_EXP_LEN);
  assign body_err_s     = (s_axis.S_AXIS_TDATA != C_S_AXIS_DATA_WIDTH'(C_EXP_BODY)) |
                          (s_axis.S_AXIS_TUSER != {C_S_AXIS_TUSER_WIDTH{1'b0}}) | ~strb_ok_s;
  assign idx_inc_s      = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};

  // Packet parser: next state, beat index and per-beat error/verdict pulses.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    good_inc_s = 1'b0;
    bad_inc_s  = 1'b0;
    err_set_s  = 4'b0000;
    if (accept_s) begin
      case (state_q)
        ST_IDLE: begin
          err_set_s[0] = hdr_data_err_s;
          err_set_s[1] = hdr_user_err_s;
          if (s_axis.S_AXIS_TLAST) begin
            err_set_s[3] = 1'b1;
            bad_inc_s    = 1'b1;
            state_d      = ST_IDLE;
            idx_d        = {IDX_W{1'b0}};
          end else if (hdr_data_err_s || hdr_user_err_s) begin
            state_d = ST_DROP;
            idx_d   = idx_inc_s;
          end else begin
            state_d = ST_BODY;
            idx_d   = idx_inc_s;
          end
        end
        ST_BODY: begin
          if (body_err_s) begin
            err_set_s[2] = 1'b1;
            if (s_axis.S_AXIS_TLAST) begin
              bad_inc_s = 1'b1;
              state_d   = ST_IDLE;
              idx_d     = {IDX_W{1'b0}};
            end else begin
              state_d = ST_DROP;
              idx_d   = idx_inc_s;
            end
          end else if (s_axis.S_AXIS_TLAST) begin
            if (idx_inc_s == IDX_LAST) begin
              good_inc_s = 1'b1;
            end else begin
              bad_inc_s    = 1'b1;
              err_set_s[3] = 1'b1;
            end
            state_d = ST_IDLE;
            idx_d   = {IDX_W{1'b0}};
          end else if (idx_inc_s == IDX_LAST) begin
            err_set_s[3] = 1'b1;
            state_d      = ST_DROP;
            idx_d        = idx_inc_s;
          end else begin
            state_d = ST_BODY;
            idx_d   = idx_inc_s;
          end
        end
        ST_DROP: begin
          if (s_axis.S_AXIS_TLAST) begin
            bad_inc_s = 1'b1;
            state_d   = ST_IDLE;
            idx_d     = {IDX_W{1'b0}};
          end else if (idx_q == IDX_LAST) begin
            idx_d = idx_q;
          end else begin
            idx_d = idx_inc_s;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = {IDX_W{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
      idx_d   = idx_q;
    end
  end

  // State, phase, counters and sticky flags; a counter clear beats a same-cycle increment.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state_q        <= ST_IDLE;
      idx_q          <= {IDX_W{1'b0}};
      phase_q        <= 2'd0;
      good_pkt_cnt_q <= 32'd0;
      bad_pkt_cnt_q  <= 32'd0;
      beat_cnt_q     <= 32'd0;
      err_flags_q    <= 4'b0000;
      in_packet_q    <= 1'b0;
    end else begin
      phase_q     <= phase_q + 2'd1;
      state_q     <= state_d;
      idx_q       <= idx_d;
      in_packet_q <= (state_d == ST_BODY) || (state_d == ST_DROP);
      if (rst_cntrs) begin
        good_pkt_cnt_q <= 32'd0;
        bad_pkt_cnt_q  <= 32'd0;
        beat_cnt_q     <= 32'd0;
        err_flags_q    <= 4'b0000;
      end else begin
        good_pkt_cnt_q <= sat_inc(good_pkt_cnt_q, good_inc_s);
        bad_pkt_cnt_q  <= sat_inc(bad_pkt_cnt_q, bad_inc_s);
        beat_cnt_q     <= sat_inc(beat_cnt_q, accept_s);
        err_flags_q    <= err_flags_q | err_set_s;
      end
    end
  end

  assign good_pkt_cnt = good_pkt_cnt_q;
  assign bad_pkt_cnt  = bad_pkt_cnt_q;
  assign beat_cnt     = beat_cnt_q;
  assign err_flags    = err_flags_q;
  assign in_packet    = in_packet_q;

endmodule

// File: tb/tb_simple_rx_checker.sv
// Scoreboard bench: each issued beat queues its expected counter snapshot,
// and a monitor compares it the cycle after the DUT accepts that beat.
module tb_simple_rx_checker;

  localparam logic [63:0]  HDR  = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0]  BODY = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [127:0] ULEN = 128'h40;

  typedef struct packed {
    logic [31:0] good;
    logic [31:0] bad;
    logic [31:0] beats;
    logic [3:0]  flags;
    logic        inpkt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rst_cntrs;
  logic [3:0]  ready_mask;
  logic [31:0] good_pkt_cnt, bad_pkt_cnt, beat_cnt;
  logic [3:0]  err_flags;
  logic        in_packet;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic hs_seen = 1'b0;
  logic prev_rdy;

  simple_rx_checker_if #(.C_DATA_WIDTH(64), .C_TUSER_WIDTH(128)) axis_if ();

  simple_rx_checker dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rstn),
    .s_axis        (axis_if),
    .rst_cntrs     (rst_cntrs),
    .ready_mask    (ready_mask),
    .good_pkt_cnt  (good_pkt_cnt),
    .bad_pkt_cnt   (bad_pkt_cnt),
    .beat_cnt      (beat_cnt),
    .err_flags     (err_flags),
    .in_packet     (in_packet)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] g, input logic [31:0] b,
                              input logic [31:0] n, input logic [3:0] f, input logic ip);
    exp_t e;
    e.good = g; e.bad = b; e.beats = n; e.flags = f; e.inpkt = ip;
    return e;
  endfunction

  // Monitor: a handshake seen at a rising edge is checked on the next falling edge.
  always @(posedge clk) hs_seen <= rstn && axis_if.S_AXIS_TVALID && axis_if.S_AXIS_TREADY;

  always @(negedge clk) begin
    if (hs_seen) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("good_pkt_cnt", good_pkt_cnt, mon_e.good);
        chk("bad_pkt_cnt",  bad_pkt_cnt,  mon_e.bad);
        chk("beat_cnt",     beat_cnt,     mon_e.beats);
        chk("err_flags",    {28'd0, err_flags}, {28'd0, mon_e.flags});
        chk("in_packet",    {31'd0, in_packet}, {31'd0, mon_e.inpkt});
      end
    end
  end

  task automatic send_beat(input logic [63:0] data, input logic [127:0] user,
                           input logic [7:0] strb, input logic last,
                           input exp_t e, input logic rc);
    logic acc;
    int   cyc;
    @(posedge clk); #1;
    exp_q.push_back(e);
    axis_if.S_AXIS_TDATA  = data;
    axis_if.S_AXIS_TUSER  = user;
    axis_if.S_AXIS_TSTRB  = strb;
    axis_if.S_AXIS_TLAST  = last;
    axis_if.S_AXIS_TVALID = 1'b1;
    rst_cntrs             = rc;
    acc = 1'b0;
    cyc = 0;
    while (!acc && cyc < 50) begin
      @(negedge clk);
      acc = axis_if.S_AXIS_TREADY;
      @(posedge clk); #1;
      cyc++;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    axis_if.S_AXIS_TVALID = 1'b0;
    axis_if.S_AXIS_TLAST  = 1'b0;
    rst_cntrs             = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_cntrs();
    @(posedge clk); #1 rst_cntrs = 1'b1;
    @(posedge clk); #1 rst_cntrs = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; rst_cntrs = 1'b0; ready_mask = 4'b1110;
    axis_if.S_AXIS_TVALID = 1'b0; axis_if.S_AXIS_TLAST = 1'b0;
    axis_if.S_AXIS_TDATA = 64'd0; axis_if.S_AXIS_TUSER = 128'd0; axis_if.S_AXIS_TSTRB = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tready_mask0", {31'd0, axis_if.S_AXIS_TREADY}, 32'd0);
    chk("reset_good", good_pkt_cnt, 32'd0);
    chk("reset_bad", bad_pkt_cnt, 32'd0);
    chk("reset_beats", beat_cnt, 32'd0);
    chk("reset_flags", {28'd0, err_flags}, 32'd0);
    chk("reset_in_packet", {31'd0, in_packet}, 32'd0);
    ready_mask = 4'hF;
    @(posedge clk); #1 rstn = 1'b1;

    // Three clean packets, always ready.
    for (int p = 0; p < 3; p++) begin
      send_beat(HDR,  ULEN,   8'hFF, 1'b0, mk(p,     0, 2*p+1, 4'h0, 1'b1), 1'b0);
      send_beat(BODY, 128'd0, 8'hFF, 1'b1, mk(p + 1, 0, 2*p+2, 4'h0, 1'b0), 1'b0);
    end
    idle(2);

    // Same traffic under alternating backpressure.
    clear_cntrs();
    ready_mask = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk) prev_rdy = axis_if.S_AXIS_TREADY;
      @(negedge clk) chk("tready_toggle", {31'd0, axis_if.S_AXIS_TREADY}, {31'd0, ~prev_rdy});
    end
    for (int p = 0; p < 3; p++) begin
      send_beat(HDR,  ULEN,   8'hFF, 1'b0, mk(p,     0, 2*p+1, 4'h0, 1'b1), 1'b0);
      send_beat(BODY, 128'd0, 8'hFF, 1'b1, mk(p + 1, 0, 2*p+2, 4'h0, 1'b0), 1'b0);
    end
    idle(2);
    ready_mask = 4'hF;

    // Corrupt header data.
    clear_cntrs();
    send_beat(64'h1234, ULEN,   8'hFF, 1'b0, mk(0, 0, 1, 4'b0001, 1'b1), 1'b0);
    send_beat(BODY,     128'd0, 8'hFF, 1'b1, mk(0, 1, 2, 4'b0001, 1'b0), 1'b0);
    idle(2);

    // One-beat packet, then a three-beat packet.
    clear_cntrs();
    send_beat(HDR,  ULEN,   8'hFF, 1'b1, mk(0, 1, 1, 4'b1000, 1'b0), 1'b0);
    send_beat(HDR,  ULEN,   8'hFF, 1'b0, mk(0, 1, 2, 4'b1000, 1'b1), 1'b0);
    send_beat(BODY, 128'd0, 8'hFF, 1'b0, mk(0, 1, 3, 4'b1000, 1'b1), 1'b0);
    send_beat(BODY, 128'd0, 8'hFF, 1'b1, mk(0, 2, 4, 4'b1000, 1'b0), 1'b0);
    idle(2);

    // Saturation of the good counter, then a clear colliding with TLAST.
    clear_cntrs();
    force dut.good_pkt_cnt_q = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.good_pkt_cnt_q;
    send_beat(HDR,  ULEN,   8'hFF, 1'b0, mk(32'hFFFF_FFFF, 0, 1, 4'h0, 1'b1), 1'b0);
    send_beat(BODY, 128'd0, 8'hFF, 1'b1, mk(32'hFFFF_FFFF, 0, 2, 4'h0, 1'b0), 1'b0);
    send_beat(HDR,  ULEN,   8'hFF, 1'b0, mk(32'hFFFF_FFFF, 0, 3, 4'h0, 1'b1), 1'b0);
    send_beat(BODY, 128'd0, 8'hFF, 1'b1, mk(0, 0, 0, 4'h0, 1'b0), 1'b1);
    idle(2);

    // Reset after the header: the body is parsed as a one-beat header.
    send_beat(HDR, ULEN, 8'hFF, 1'b0, mk(0, 0, 1, 4'h0, 1'b1), 1'b0);
    idle(1);
    rstn = 1'b0;
    idle(2);
    @(negedge clk) chk("midreset_in_packet", {31'd0, in_packet}, 32'd0);
    @(posedge clk); #1 rstn = 1'b1;
    send_beat(BODY, 128'd0, 8'hFF, 1'b1, mk(0, 1, 1, 4'b1011, 1'b0), 1'b0);
    idle(4);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
